// File: rtl/clock_pkg.sv
// Shared digit limits, widths and types for the HH:MM clock core.
// Digit fields are laid out so a packed time value reads as HHMM in hex.
package clock_pkg;

  localparam int HR_TENS_W = 2;
  localparam int DIGIT_W   = 4;
  localparam int TICK_W    = 6;

  localparam logic [DIGIT_W-1:0]   MIN_UNITS_MAX      = 4'd9;
  localparam logic [DIGIT_W-1:0]   MIN_TENS_MAX       = 4'd5;
  localparam logic [HR_TENS_W-1:0] HR_TENS_MAX        = 2'd2;
  localparam logic [DIGIT_W-1:0]   HR_UNITS_MAX       = 4'd9;
  localparam logic [DIGIT_W-1:0]   HR_UNITS_MAX_AT_20 = 4'd3;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_TICK,
    EV_MIN,
    EV_HR
  } event_e;

  typedef struct packed {
    logic [HR_TENS_W-1:0] hr1;
    logic [DIGIT_W-1:0]   hr2;
    logic [DIGIT_W-1:0]   min1;
    logic [DIGIT_W-1:0]   min2;
  } hhmm_t;

  localparam hhmm_t MIDNIGHT = '0;

endpackage

// File: rtl/odliczanie_sync_edge.sv
// Multi-flop synchronizer followed by a rising-edge detector.
// rise_o is high for one clk_i cycle per synchronized 0->1 transition.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   dly_p1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_p0 <= '0;
      dly_p1  <= 1'b0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], async_i};
      dly_p1  <= sync_p0[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_p0[SYNC_STAGES-1] & ~dly_p1;

endmodule

// File: rtl/odliczanie.sv
// 24-hour BCD clock core: minute ticks from a slow timebase plus
// single-shot hour/minute set buttons, all sampled in the clk_i domain.
module odliczanie
  import clock_pkg::*;
#(
  parameter int TICKS_PER_MIN = 60,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 div_clk,
  input  logic                 button_hr_i,
  input  logic                 button_min_i,
  output logic [HR_TENS_W-1:0] hr1_o,
  output logic [DIGIT_W-1:0]   hr2_o,
  output logic [DIGIT_W-1:0]   min1_o,
  output logic [DIGIT_W-1:0]   min2_o
);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_MIN - 1);

  logic        tick_rise;
  logic        hr_rise;
  logic        min_rise;
  event_e      ev_sel;
  hhmm_t       time_p0;
  logic [TICK_W-1:0] tick_p0;

  function automatic hhmm_t hour_inc(input hhmm_t t);
    hhmm_t r;
    r = t;
    if (t.hr1 == HR_TENS_MAX && t.hr2 == HR_UNITS_MAX_AT_20) begin
      r.hr1 = '0;
      r.hr2 = '0;
    end else if (t.hr2 == HR_UNITS_MAX) begin
      r.hr2 = '0;
      r.hr1 = t.hr1 + 2'd1;
    end else begin
      r.hr2 = t.hr2 + 4'd1;
    end
    return r;
  endfunction

  function automatic hhmm_t minute_wrap(input hhmm_t t);
    hhmm_t r;
    r = t;
    if (t.min2 == MIN_UNITS_MAX) begin
      r.min2 = '0;
      r.min1 = (t.min1 == MIN_TENS_MAX) ? '0 : t.min1 + 4'd1;
    end else begin
      r.min2 = t.min2 + 4'd1;
    end
    return r;
  endfunction

  function automatic hhmm_t minute_advance(input hhmm_t t);
    hhmm_t r;
    r = minute_wrap(t);
    if (t.min1 == MIN_TENS_MAX && t.min2 == MIN_UNITS_MAX)
      r = hour_inc(r);
    return r;
  endfunction

  // Input conditioning: each asynchronous input becomes a one-cycle event
  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_tick (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .async_i (div_clk),
    .rise_o  (tick_rise)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_hr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .async_i (button_hr_i),
    .rise_o  (hr_rise)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_min (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .async_i (button_min_i),
    .rise_o  (min_rise)
  );

  always_comb begin
    ev_sel = EV_NONE;
    if (hr_rise)
      ev_sel = EV_HR;
    else if (min_rise)
      ev_sel = EV_MIN;
    else if (tick_rise)
      ev_sel = EV_TICK;
  end

  // Time-keeping state: only the winning event of a cycle takes effect
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      time_p0 <= MIDNIGHT;
      tick_p0 <= '0;
    end else begin
      case (ev_sel)
        EV_HR: time_p0 <= hour_inc(time_p0);
        EV_MIN: begin
          time_p0 <= minute_wrap(time_p0);
          tick_p0 <= '0;
        end
        EV_TICK: begin
          if (tick_p0 == TICK_LAST) begin
            tick_p0 <= '0;
            time_p0 <= minute_advance(time_p0);
          end else begin
            tick_p0 <= tick_p0 + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign hr1_o  = time_p0.hr1;
  assign hr2_o  = time_p0.hr2;
  assign min1_o = time_p0.min1;
  assign min2_o = time_p0.min2;

endmodule

// File: tb/tb_odliczanie.sv
// Bench for odliczanie: directed scenarios and random stimulus, every cycle
// compared against a minutes/hours integer model with an input-latency queue.
module tb_odliczanie;

  localparam int TPM  = 2;
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       div_clk = 1'b0;
  logic       bh = 1'b0;
  logic       bm = 1'b0;
  logic [1:0] hr1;
  logic [3:0] hr2, min1, min2;
  logic [13:0] dut_t;

  int n_chk  = 0;
  int n_pass = 0;

  int hh, mm, tk;
  logic pd, ph, pm;
  logic [2:0] pend[$];

  odliczanie #(.TICKS_PER_MIN(TPM), .SYNC_STAGES(SYNC)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .div_clk      (div_clk),
    .button_hr_i  (bh),
    .button_min_i (bm),
    .hr1_o        (hr1),
    .hr2_o        (hr2),
    .min1_o       (min1),
    .min2_o       (min2)
  );

  always #5 clk = ~clk;

  assign dut_t = {hr1, hr2, min1, min2};

  task automatic chk(input string tag, input logic [13:0] got, input logic [13:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h (HHMM) expected %h (HHMM) at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [13:0] model_t();
    logic [1:0] a;
    logic [3:0] b, c, d;
    a = 2'(hh / 10);
    b = 4'(hh % 10);
    c = 4'(mm / 10);
    d = 4'(mm % 10);
    return {a, b, c, d};
  endfunction

  task automatic model_reset();
    hh = 0; mm = 0; tk = 0;
    pd = 1'b0; ph = 1'b0; pm = 1'b0;
    pend.delete();
    for (int i = 0; i < SYNC; i++) pend.push_back(3'b000);
  endtask

  // An input seen high at edge k (low at k-1) takes effect at edge k+SYNC.
  task automatic model_edge(input logic d, input logic h, input logic m);
    logic [2:0] ev;
    ev = pend.pop_front();
    pend.push_back({h & ~ph, m & ~pm, d & ~pd});
    pd = d; ph = h; pm = m;
    if (ev[2]) hh = (hh + 1) % 24;
    else if (ev[1]) begin
      mm = (mm + 1) % 60;
      tk = 0;
    end else if (ev[0]) begin
      tk++;
      if (tk == TPM) begin
        tk = 0;
        mm++;
        if (mm == 60) begin
          mm = 0;
          hh = (hh + 1) % 24;
        end
      end
    end
  endtask

  task automatic step(input logic d, input logic h, input logic m);
    @(negedge clk);
    div_clk = d; bh = h; bm = m;
    @(posedge clk);
    model_edge(d, h, m);
    #1;
    chk("model", dut_t, model_t());
  endtask

  task automatic settle();
    repeat (SYNC + 1) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic press_hr();
    step(1'b0, 1'b1, 1'b0);
    settle();
  endtask

  task automatic press_min();
    step(1'b0, 1'b0, 1'b1);
    settle();
  endtask

  task automatic div_edges(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
    settle();
  endtask

  task automatic set_time(input int h, input int m);
    while (hh != h) press_hr();
    while (mm != m) press_min();
  endtask

  task automatic async_reset(input string tag);
    @(posedge clk);
    #2;
    rst = 1'b1;
    div_clk = 1'b0; bh = 1'b0; bm = 1'b0;
    #1;
    chk(tag, dut_t, 14'h0000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic rd, rh, rm;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // warm up with random activity so the reset check starts from a nonzero time
    rd = 1'b0; rh = 1'b0; rm = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 1) == 0) rd = ~rd;
      if ($urandom_range(0, 5) == 0) rh = ~rh;
      if ($urandom_range(0, 5) == 0) rm = ~rm;
      step(rd, rh, rm);
    end
    settle();
    async_reset("rst_async");
    repeat (100) step(1'b0, 1'b0, 1'b0);
    chk("idle_100", dut_t, 14'h0000);

    div_edges(2);
    chk("min_first", dut_t, 14'h0001);
    div_edges(116);
    chk("min_59", dut_t, 14'h0059);
    div_edges(2);
    chk("hour_carry", dut_t, 14'h0100);

    set_time(23, 59);
    chk("set_2359", dut_t, 14'h2359);
    div_edges(TPM);
    chk("day_wrap", dut_t, 14'h0000);

    async_reset("rst_async2");
    step(1'b0, 1'b1, 1'b0);
    chk("bhr_edge1", dut_t, 14'h0000);
    step(1'b0, 1'b1, 1'b0);
    chk("bhr_edge2", dut_t, 14'h0000);
    step(1'b0, 1'b1, 1'b0);
    chk("bhr_edge3", dut_t, 14'h0100);
    repeat (47) step(1'b0, 1'b1, 1'b0);
    chk("bhr_hold", dut_t, 14'h0100);
    settle();
    repeat (50) step(1'b0, 1'b0, 1'b1);
    settle();
    chk("bmin_hold", dut_t, 14'h0101);

    set_time(5, 59);
    press_min();
    chk("min_wrap", dut_t, 14'h0500);
    set_time(23, 10);
    press_hr();
    chk("hr_wrap", dut_t, 14'h0010);

    set_time(12, 30);
    div_edges(1);
    chk("prio_pre", dut_t, 14'h1230);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    settle();
    chk("prio_single", dut_t, 14'h1231);
    div_edges(1);
    chk("prio_tick0", dut_t, 14'h1231);
    div_edges(1);
    chk("prio_next", dut_t, 14'h1232);

    // random soak, including coincident edges and a mid-run reset
    rd = 1'b0; rh = 1'b0; rm = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      if (i == 3000) begin
        settle();
        async_reset("rst_soak");
        rd = 1'b0; rh = 1'b0; rm = 1'b0;
      end
      if ($urandom_range(0, 1) == 0) rd = ~rd;
      if ($urandom_range(0, 15) == 0) rh = ~rh;
      if ($urandom_range(0, 11) == 0) rm = ~rm;
      step(rd, rh, rm);
    end
    settle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/odliczanie.md
Name: odliczanie

Overview:
- Real-time 24-hour clock core. Keeps time as four BCD digits HH:MM.
- Advances once per minute, derived from a slow timebase input (div_clk) sampled in the clk_i domain.
- Two push-button inputs set the time: one advances hours, one advances minutes.
- Outputs feed the display multiplexer/decoder downstream.

Parameters:
- TICKS_PER_MIN, 60, number of div_clk rising edges per minute advance (legal range 1..63).
- SYNC_STAGES, 2, flip-flop depth of the input synchronizers (minimum 2).

Ports:
- clk_i  input  1  system clock; all state on its rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- div_clk  input  1  slow timebase (nominally 1 Hz), asynchronous to clk_i; treated as data, never as a clock.
- button_hr_i  input  1  hour-set button, active-high, asynchronous.
- button_min_i  input  1  minute-set button, active-high, asynchronous.
- hr1_o  output  2  hours tens digit, 0..2.
- hr2_o  output  4  hours units digit, 0..9 (0..3 when hr1_o=2).
- min1_o  output  4  minutes tens digit, 0..5.
- min2_o  output  4  minutes units digit, 0..9.

Behaviour:
- Reset (rst_i=1, asynchronous): all digits 0 (00:00), tick counter 0, synchronizer and edge-detect flops 0. Held while rst_i=1; normal operation on the first clk_i edge after release.
- Input conditioning:
  - div_clk, button_hr_i and button_min_i each pass through a SYNC_STAGES-flop synchronizer plus one delay flop.
  - An event is the synchronized rise (sync=1, delayed=0), one clk_i cycle wide.
  - Latency: input rising before clk_i edge N gives an output update at edge N+SYNC_STAGES (edge 3 with default).
  - Falling edges produce no event. A held button produces exactly one event per press; there is no auto-repeat.
- Tick path (div_clk event):
  - Tick counter increments.
  - When the counter equals TICKS_PER_MIN-1 it wraps to 0 and a minute advance occurs in the same cycle.
- Minute advance (with carry):
  - min2 9->0 carries into min1.
  - min1 5->0 (at :59) carries into an hour advance.
- Hour advance:
  - hr2 9->0 carries into hr1.
  - 23 wraps to 00; digits never take the value 24.
- button_min event: minutes +1 modulo 60 (59->00) with no carry into hours; tick counter cleared to 0.
- button_hr event: hours +1 modulo 24 (23->00); minutes and tick counter unchanged.
- Simultaneous events in one cycle: priority is button_hr > button_min > tick. Only the highest-priority event acts; lower-priority events that cycle are discarded, including the tick-counter increment.
- All outputs are direct register outputs with no combinational path from inputs. Digits are always valid BCD within the ranges above.
- Reset asserted mid-operation returns to 00:00 immediately; pending edges are lost.

Decomposition:
- Shared package (clock_pkg):
  - digit limits: MIN_UNITS_MAX=9, MIN_TENS_MAX=5, HR_TENS_MAX=2, HR_UNITS_MAX_AT_20=3.
  - digit width constants: 2 and 4.
- One natural sub-module: sync_edge (parameterised synchronizer + rising-edge detector), instantiated three times.
- Counters and BCD carry logic stay in odliczanie.

Test Plan:
- Reset: assert rst_i asynchronously mid-cycle -> outputs 0,0,0,0 immediately. Release, no inputs for 100 clk_i cycles -> still 00:00.
- Minute rollover (TICKS_PER_MIN=2): start 00:00, apply 2 div_clk rising edges -> 00:01. Continue to 00:59, then 2 more edges -> 01:00 (hr2=1, min1=0, min2=0).
- Day wrap: use button_hr to reach 23, button_min to reach :59, apply TICKS_PER_MIN div_clk edges -> 00:00.
- Button single-shot: hold button_hr_i high for 50 clk_i cycles from 00:00 -> hr=01 exactly, first visible at the 3rd clk_i edge. Release, then hold button_min_i 50 cycles -> 01:01.
- Button wraps without carry: at 05:59 press button_min -> 05:00. At 23:10 press button_hr -> 00:10.
- Priority: align a button_min rise and a div_clk rise that completes a minute in the same synchronized cycle at 12:30 -> 12:31 (single increment) and tick counter 0.
